// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states,
// "all dark" output constants, the hex glyph table and the helper that
// works out which leading digits are zero.
// Configuration macro: SEG_LZ_BLANK_EN (leading-zero suppression, used by seg_scan_driver).
package seg_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam logic [7:0] DIGIT_OFF = 8'hFF;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    // Active-low glyphs {g,f,e,d,c,b,a}. The dp bit is added separately by the driver.
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit i is set when nibble i and every nibble above it are zero.
    // Digit 0 is never marked, so a word of zero still shows a single "0".
    function automatic logic [7:0] lzDarkMask(input logic [31:0] word);
        logic [7:0] dark;
        logic       zeroSoFar;
        dark      = 8'h00;
        zeroSoFar = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (word[i*4 +: 4] != 4'h0) begin
                zeroSoFar = 1'b0;
            end
            dark[i] = zeroSoFar;
        end
        return dark;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-digit to seven-segment decoder (active-low, no dp).
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver. It shows a 32-bit word as
// hex, inserts a dark gap between digits, and swaps words only at frame
// boundaries so that a frame never shows a mix of two words.
// Configuration macro: SEG_LZ_BLANK_EN. When it is defined, leading zeros
// are suppressed. When it is undefined, all eight digits are always lit.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 2
) (
    input  logic        CCLK,
    input  logic        rst,
    input  logic [31:0] num,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    input  logic        blank,
    output logic [7:0]  digit,
    output logic [7:0]  segment,
    output logic        frame_done
);

    localparam logic [19:0] SHOW_TC = 20'(SCAN_DIV - 1);
    localparam logic [19:0] GAP_TC  = 20'(GAP_CYC - 1);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [19:0] r_presc;
    logic [31:0] r_shadow;
    logic [31:0] r_pending;
    logic        r_pendValid;
    logic [7:0]  r_digit;
    logic [7:0]  r_segment;
    logic        r_frameDone;

    state_t      w_stateNext;
    logic [2:0]  w_idxNext;
    logic [19:0] w_prescNext;
    logic        w_termCount;
    logic        w_boundary;
    logic        w_frameEnd;
    logic [31:0] w_shadowNext;
    logic [31:0] w_pendingNext;
    logic        w_pendValidNext;
    logic [3:0]  w_nibble;
    logic [6:0]  w_hexSeg;
    logic [7:0]  w_digitNext;
    logic [7:0]  w_segmentNext;

`ifdef SEG_LZ_BLANK_EN
    logic [7:0]  r_lzDark;
    logic [7:0]  w_lzDarkNext;
`endif

    // Sequencing: advance the prescaler, switch between SHOW and GAP, and
    // decide which word the next frame uses when the boundary is reached.
    always_comb begin
        w_stateNext     = r_state;
        w_idxNext       = r_idx;
        w_prescNext     = r_presc + 20'd1;
        w_boundary      = 1'b0;
        w_frameEnd      = 1'b0;
        w_shadowNext    = r_shadow;
        w_pendingNext   = r_pending;
        w_pendValidNext = r_pendValid;
        w_termCount     = (r_state == SHOW) ? (r_presc == SHOW_TC) : (r_presc == GAP_TC);

        if (w_termCount) begin
            w_prescNext = 20'd0;
            if (r_state == SHOW) begin
                w_stateNext = GAP;
                w_idxNext   = r_idx + 3'd1;
                w_frameEnd  = (r_idx == 3'd7);
            end else begin
                w_stateNext = SHOW;
                w_boundary  = (r_idx == 3'd0);
            end
        end

        if (load) begin
            w_pendingNext   = num;
            w_pendValidNext = 1'b1;
        end

        if (w_boundary) begin
            if (load) begin
                w_shadowNext = num;
            end else if (r_pendValid) begin
                w_shadowNext = r_pending;
            end
            w_pendValidNext = 1'b0;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    assign w_lzDarkNext = w_boundary ? lzDarkMask(w_shadowNext) : r_lzDark;
`endif

    // The outputs are computed from the next-state values. This lets the
    // registered digit and segment lines change on the same edge as the FSM.
    assign w_nibble = w_shadowNext[{w_idxNext, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_hexSeg)
    );

    // Drive the anode and cathode patterns for the slot the FSM is about to enter.
    always_comb begin
        w_digitNext   = DIGIT_OFF;
        w_segmentNext = SEG_OFF;
        if (w_stateNext == SHOW) begin
            w_digitNext   = ~(8'b1 << w_idxNext);
            w_segmentNext = {~dp_mask[w_idxNext], w_hexSeg};
`ifdef SEG_LZ_BLANK_EN
            if (w_lzDarkNext[w_idxNext] && !dp_mask[w_idxNext]) begin
                w_digitNext   = DIGIT_OFF;
                w_segmentNext = SEG_OFF;
            end
`endif
        end
        if (blank) begin
            w_digitNext = DIGIT_OFF;
        end
    end

    // FSM state, digit index and prescaler.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            r_state <= GAP;
            r_idx   <= 3'd0;
            r_presc <= 20'd0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            r_presc <= w_prescNext;
        end
    end

    // Displayed word, pending word and its valid flag.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            r_shadow    <= 32'd0;
            r_pending   <= 32'd0;
            r_pendValid <= 1'b0;
        end else begin
            r_shadow    <= w_shadowNext;
            r_pending   <= w_pendingNext;
            r_pendValid <= w_pendValidNext;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // The leading-zero mask is frozen with the word at each frame boundary.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            r_lzDark <= 8'h00;
        end else begin
            r_lzDark <= w_lzDarkNext;
        end
    end
`endif

    // Registered outputs, so the board pins see no combinational glitches.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            r_digit     <= DIGIT_OFF;
            r_segment   <= SEG_OFF;
            r_frameDone <= 1'b0;
        end else begin
            r_digit     <= w_digitNext;
            r_segment   <= w_segmentNext;
            r_frameDone <= w_frameEnd;
        end
    end

    assign digit      = r_digit;
    assign segment    = r_segment;
    assign frame_done = r_frameDone;

endmodule
